// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch front
//               end: FSM state encoding, queue entry layout, NOP filler word
//               and PC increment.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Word driven toward decode when the queue is empty (addi x0, x0, 0).
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] c_pc_incr = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit_if
// Description : Bus bundle of the fetch unit: decode redirect, instruction
//               memory request/response, decode-side instruction handshake
//               and misalign trap report.
//               master : fetch unit side
//               slave  : environment side (decode + instruction memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_unit_if;

    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        misalign_valid;
    logic [31:0] misalign_addr;

    modport master (
        input  redirect_valid, redirect_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_ready,
        output imem_req_valid, imem_req_addr,
        output inst_valid, inst_out, inst_pc,
        output misalign_valid, misalign_addr
    );

    modport slave (
        output redirect_valid, redirect_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_ready,
        input  imem_req_valid, imem_req_addr,
        input  inst_valid, inst_out, inst_pc,
        input  misalign_valid, misalign_addr
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO with flush. Head is presented
//               combinationally; flush wins over push/pop in the same cycle.
//   clk, clrn        : clock, synchronous active-low reset
//   flush            : discard all entries
//   push, push_data  : write an entry (ignored when full)
//   pop              : retire the head (ignored when empty)
//   head_data, count : head entry and occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  wire                     clk,
    input  wire                     clrn,
    input  wire                     flush,
    input  wire                     push,
    input  wire [WIDTH-1:0]         push_data,
    input  wire                     pop,
    output logic [WIDTH-1:0]        head_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = push && (r_count != c_FULL);
    assign w_pop_ok  = pop && (r_count != '0);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !flush) r_mem[r_wr_ptr] <= push_data;
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Instruction-fetch front end. Owns the PC, issues sequential
//               credit-limited memory requests, queues returned words for
//               decode and handles decode redirects by flushing the queue and
//               dropping in-flight (stale) responses.
//   clk, clrn : clock, synchronous active-low reset
//   bus       : fetch_pc_unit_if.master (redirect, imem req/rsp, inst, trap)
// Build option : FETCH_MISALIGN_TRAP_EN - misaligned redirect targets raise a
//               trap and halt fetching; otherwise target bits [1:0] are
//               cleared and the misalign outputs are tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  wire             clk,
    input  wire             clrn,
    fetch_pc_unit_if.master bus
);

    localparam int c_CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [c_CW:0] c_DEPTH = (c_CW+1)'(QUEUE_DEPTH);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [31:0]     r_pc;
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_drop;
    logic [c_CW-1:0] w_out_nxt;
    logic [c_CW-1:0] w_q_count;
    logic [c_CW-1:0] w_tag_count;
    logic [c_CW:0]   w_inflight;
    logic [31:0]     w_target;
    logic [31:0]     w_tag_pc;
    logic            w_misaligned;
    logic            w_redirect;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp_keep;
    logic            w_inst_valid;
    logic            w_pop;
    fetch_entry_t    w_q_head;
    fetch_entry_t    w_q_push;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_target     = bus.redirect_addr;
    assign w_misaligned = (bus.redirect_addr[1:0] != 2'b00);
`else
    assign w_target     = bus.redirect_addr & ~32'h0000_0003;
    assign w_misaligned = 1'b0;
`endif

    assign w_redirect   = bus.redirect_valid && (r_state != ST_INIT);
    // Requests in memory plus queued words must fit in the queue, because
    // responses cannot be back-pressured.
    assign w_inflight   = {1'b0, r_outstanding} + {1'b0, w_q_count};
    assign w_req_valid  = (r_state == ST_RUN) && (w_inflight < c_DEPTH);
    assign w_req_fire   = w_req_valid && bus.imem_req_ready;
    assign w_inst_valid = (w_q_count != '0);
    assign w_pop        = w_inst_valid && bus.inst_ready;
    // A response is kept only when it is not stale and has a recorded PC.
    assign w_rsp_keep   = bus.imem_rsp_valid && !w_redirect && (r_drop == '0)
                          && (w_tag_count != '0);

    always_comb begin
        w_out_nxt = r_outstanding;
        case ({w_req_fire, bus.imem_rsp_valid})
            2'b10:   w_out_nxt = r_outstanding + c_CW'(1);
            2'b01:   w_out_nxt = (r_outstanding != '0) ? r_outstanding - c_CW'(1)
                                                       : r_outstanding;
            default: w_out_nxt = r_outstanding;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) r_state <= ST_INIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: w_state_nxt = ST_RUN;
            ST_RUN:  if (w_redirect && w_misaligned)  w_state_nxt = ST_HALT;
            ST_HALT: if (w_redirect && !w_misaligned) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // On redirect every request still in memory (including one accepted this
    // cycle, excluding a response consumed this cycle) becomes stale.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            if (w_redirect && !w_misaligned) r_pc <= w_target;
            else if (w_req_fire)             r_pc <= r_pc + c_pc_incr;
            if (w_redirect)
                r_drop <= w_out_nxt;
            else if (bus.imem_rsp_valid && (r_drop != '0))
                r_drop <= r_drop - c_CW'(1);
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        r_mis_valid;
    logic [31:0] r_mis_addr;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_mis_valid <= 1'b0;
            r_mis_addr  <= '0;
        end else if (w_redirect) begin
            r_mis_valid <= w_misaligned;
            if (w_misaligned) r_mis_addr <= w_target;
        end
    end

    assign bus.misalign_valid = r_mis_valid;
    assign bus.misalign_addr  = r_mis_addr;
`else
    assign bus.misalign_valid = 1'b0;
    assign bus.misalign_addr  = '0;
`endif

    assign w_q_push = '{pc: w_tag_pc, inst: bus.imem_rsp_data};

    fetch_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_inst_q (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (w_redirect),
        .push      (w_rsp_keep),
        .push_data (w_q_push),
        .pop       (w_pop),
        .head_data (w_q_head),
        .count     (w_q_count)
    );

    // PC tags of live requests, paired in order with their responses.
    fetch_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (32)
    ) u_tag_q (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (w_redirect),
        .push      (w_req_fire && !w_redirect),
        .push_data (r_pc),
        .pop       (w_rsp_keep),
        .head_data (w_tag_pc),
        .count     (w_tag_count)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = w_inst_valid;
    assign bus.inst_out       = w_inst_valid ? w_q_head.inst : INST_NOP;
    assign bus.inst_pc        = w_inst_valid ? w_q_head.pc : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Randomized self-checking bench for fetch_pc_unit. A reference
//               model tracks the architectural instruction stream, request
//               credit, stale responses and trap state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    fetch_pc_unit_if bus();

    fetch_pc_unit #(
        .RESET_PC    (RST_PC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // Reference model state
    logic [31:0] memq_addr [$];
    int          memq_due  [$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat_max = 1;
    int          model_q = 0;
    int          stale = 0;
    int          delivered = 0;
    logic [31:0] exp_pc, exp_req, mis_addr, redir_tgt;
    bit          halted, chk_addr, chk_iv, first_after_reset;

    task automatic step(input int mode, input logic [31:0] tgt, input bit rdy,
                        input bit irdy, output bit fired);
        bit          iv, rv, mv, rsp, do_redir, exp_rv;
        logic [31:0] ipc, iout, raddr, maddr, t;
        int          d;
        @(negedge clk);
        iv = bus.inst_valid;  ipc = bus.inst_pc;  iout = bus.inst_out;
        rv = bus.imem_req_valid; raddr = bus.imem_req_addr;
        mv = bus.misalign_valid; maddr = bus.misalign_addr;
        do_redir = (mode == 1) || (mode == 2 && iv && rv);
        fired = do_redir;
        rsp = (memq_due.size() > 0) && (memq_due[0] <= cyc);
        bus.redirect_valid = do_redir;
        bus.redirect_addr  = tgt;
        bus.imem_req_ready = rdy;
        bus.inst_ready     = irdy;
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_word(memq_addr[0]) : $urandom;

        if (first_after_reset) begin
            check_val("first_req_addr", raddr, RST_PC);
            first_after_reset = 0;
        end
        if (chk_addr) check_val("redir_req_addr", raddr, redir_tgt);
        if (chk_iv)   check_val("redir_inst_valid", iv, 0);
        chk_addr = 0; chk_iv = 0;

        exp_rv = !halted && (memq_due.size() + model_q < DEPTH);
        check_val("req_valid", rv, exp_rv);
        check_val("inst_valid", iv, model_q > 0);
        if (!iv) check_val("nop_out", iout, INST_NOP);
        if (rv)  check_val("req_addr", raddr, exp_req);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_val("misalign_valid", mv, halted);
        if (halted) check_val("misalign_addr", maddr, mis_addr);
`else
        check_val("misalign_valid", mv, 0);
        check_val("misalign_addr", maddr, 0);
`endif

        if (model_q > 0 && irdy) begin
            check_val("inst_pc", ipc, exp_pc);
            check_val("inst_out", iout, mem_word(exp_pc));
            exp_pc += 32'd4;
            model_q--;
            delivered++;
        end
        if (rsp) begin
            void'(memq_addr.pop_front());
            void'(memq_due.pop_front());
            if (!do_redir) begin
                if (stale > 0) stale--;
                else           model_q++;
            end
        end
        if (rv && rdy) begin
            d = cyc + int'($urandom_range(1, lat_max));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            memq_addr.push_back(raddr);
            memq_due.push_back(d);
            exp_req += 32'd4;
        end
        if (do_redir) begin
            model_q = 0;
            stale   = memq_due.size();
            chk_iv  = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
            t = tgt;
            if (tgt[1:0] != 2'b00) begin
                halted   = 1;
                mis_addr = tgt;
            end else begin
                halted = 0;
            end
`else
            t = {tgt[31:2], 2'b00};
`endif
            if (!halted) begin
                exp_pc = t; exp_req = t; redir_tgt = t; chk_addr = 1;
            end
        end
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clrn = 1'b0;
        bus.redirect_valid = 0; bus.redirect_addr = '0;
        bus.imem_req_ready = 1; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
        bus.inst_ready = 1;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_req_valid", bus.imem_req_valid, 0);
        check_val("rst_inst_valid", bus.inst_valid, 0);
        check_val("rst_misalign_valid", bus.misalign_valid, 0);
        check_val("rst_misalign_addr", bus.misalign_addr, 0);
        check_val("rst_inst_out", bus.inst_out, INST_NOP);
        check_val("rst_req_addr", bus.imem_req_addr, RST_PC);
        clrn = 1'b1;
        check_val("init_req_valid", bus.imem_req_valid, 0);
        memq_addr.delete(); memq_due.delete();
        last_due = cyc; model_q = 0; stale = 0;
        exp_pc = RST_PC; exp_req = RST_PC;
        halted = 0; chk_addr = 0; chk_iv = 0; first_after_reset = 1;
    endtask

    initial begin
        bit          f;
        logic [31:0] t;
        int          mode;
        clrn = 1'b0;
        lat_max = 1;
        apply_reset();
        // Streaming with 1-cycle memory and always-ready decode.
        repeat (10) step(0, 0, 1, 1, f);
        // Decode stall, then drain.
        apply_reset();
        repeat (10) step(0, 0, 1, 0, f);
        repeat (8)  step(0, 0, 1, 1, f);
        // Redirect with requests in flight on a slower memory.
        apply_reset();
        lat_max = 4;
        repeat (2) step(0, 0, 1, 0, f);
        step(1, 32'h0000_0100, 1, 0, f);
        repeat (14) step(0, 0, 1, 1, f);
        // Redirect coinciding with a pop and a request handshake.
        lat_max = 1;
        f = 0;
        for (int i = 0; i < 40 && !f; i++) step(2, 32'h0000_0400, 1, 1, f);
        check_val("busy_redirect_fired", f, 1);
        repeat (10) step(0, 0, 1, 1, f);
        // Memory not ready for 5 cycles.
        repeat (5) step(0, 0, 0, 1, f);
        repeat (6) step(0, 0, 1, 1, f);
        // Misaligned target, then an aligned one; PC wrap at the top.
        step(1, 32'h0000_0202, 1, 1, f);
        repeat (6) step(0, 0, 1, 1, f);
        step(1, 32'h0000_0300, 1, 1, f);
        repeat (8) step(0, 0, 1, 1, f);
        step(1, 32'hffff_fff8, 1, 1, f);
        repeat (10) step(0, 0, 1, 1, f);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) lat_max = $urandom_range(1, 4);
            if (i == 1500) apply_reset();
            t = $urandom & 32'h0000_fffc;
            if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) t = 32'hffff_fff0;
            mode = ($urandom_range(0, 24) == 0) ? 1 : 0;
            step(mode, t, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, f);
        end
        check_val("progress", delivered > 300, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end of the pipeline. It owns the program counter and issues sequential instruction-memory requests. It buffers returned instructions in a small queue for the decode stage. It accepts the control-transfer redirect (jal/jalr/branch target) produced in decode, discarding wrong-path fetches that are in flight or already queued.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `QUEUE_DEPTH`, 2: fetch queue entries; power of two, 2..8.
- `clk` input 1: sole clock, rising edge.
- `clrn` input 1: reset, synchronous and active-low.
- `redirect_valid` input 1: decode requests a PC change this cycle.
- `redirect_addr` input 32: target address; already LSB-cleared for jalr.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts the request.
- `imem_req_addr` output 32: word address of the request.
- `imem_rsp_valid` input 1: response returned; responses arrive in order, no backpressure.
- `imem_rsp_data` input 32: instruction word.
- `inst_valid` output 1: queue head valid toward decode.
- `inst_ready` input 1: decode consumes the head.
- `inst_out` output 32: head instruction.
- `inst_pc` output 32: PC of the head instruction.
- `misalign_valid` output 1: fetch-misaligned trap pending (only when `FETCH_MISALIGN_TRAP_EN` is defined; otherwise tied 0).
- `misalign_addr` output 32: offending target.

## Operation
- FSM states:
  - INIT: the one cycle after reset release.
  - RUN: normal fetching.
  - HALT: after a misalign trap.
- FSM transitions:
  - INIT→RUN unconditionally.
  - RUN→HALT on a misaligned redirect.
  - HALT→RUN on the next aligned redirect.
- Credit rule: `imem_req_valid` is asserted only in RUN, and only when outstanding + queue occupancy < `QUEUE_DEPTH`. This keeps the queue from overflowing because responses cannot be stalled.
- PC advance: when a request handshakes, `pc` advances by 4, wrapping mod 2^32. Each request's PC is pushed into a PC FIFO of depth `QUEUE_DEPTH`, paired with its response on return.
- Outstanding counter (width log2(`QUEUE_DEPTH`)+1):
  - +1 on request handshake.
  - −1 on response.
  - Both in the same cycle: unchanged.
- Redirect, accepted in RUN or HALT:
  - `pc` ← `redirect_addr`.
  - Queue flushed.
  - Drop counter ← outstanding count, including a request handshaking in the same cycle.
  - Responses arriving while the drop counter > 0 are discarded and decrement it.
- Simultaneous redirect and `inst_valid`&&`inst_ready`: the pop completes, and all other entries are discarded.
- Simultaneous redirect and response: the response counts as stale.

## Timing
- Reset values (cycle after `clrn` low at a clock edge):
  - `pc` = `RESET_PC`; state INIT.
  - All counters 0.
  - `imem_req_valid` = `inst_valid` = `misalign_valid` = 0.
  - `misalign_addr` = 0.
- First request: `imem_req_valid` is asserted with `imem_req_addr` = `RESET_PC` in the 2nd cycle after reset release.
- `imem_req_addr` is held stable while `imem_req_valid` is high and `imem_req_ready` is low, except when a redirect occurs, which retargets it.
- Response to `inst_valid`: a response in cycle N makes `inst_valid` high in N+1, registered.
- Redirect latency: a redirect in cycle N gives `imem_req_addr` = target in N+1, and `inst_valid` = 0 in N+1.
- Reset mid-operation: all state is cleared. Responses to pre-reset requests still in memory are the memory's responsibility and are not tracked.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_addr[1:0]` != 0 does not update `pc`, flushes the queue, and enters HALT.
  - `misalign_valid` = 1 and `misalign_addr` = target from the next cycle until the next aligned redirect.
  - No requests are issued in HALT.
- Not defined:
  - `redirect_addr[1:0]` is forced to 0; no HALT state; misalign outputs are tied 0.

## Structure
- Shared package `fetch_pkg`:
  - FSM state enum.
  - `INST_NOP` = 32'h0000_0013, driven on `inst_out` when the queue is empty.
  - PC increment constant 4.
- One sub-module, `fetch_fifo`: synchronous FIFO of {pc, inst} with flush, push, pop and occupancy count, instantiated once for the queue. The PC tag FIFO is a second instance of `fetch_fifo`.

## Test plan
- Reset release, `imem_req_ready`=1, fixed 1-cycle response latency, `inst_ready`=1:
  - Requests at 0x0, 0x4, 0x8 on consecutive cycles.
  - `inst_pc` sequence 0x0, 0x4, 0x8 with matching data.
- `inst_ready`=0 for 10 cycles:
  - Requests stop after 2 outstanding + queued.
  - Queue holds 0x0 and 0x4.
  - No data lost after `inst_ready` returns to 1.
- Redirect to 0x100 while 2 requests are outstanding:
  - Both stale responses are dropped.
  - The next `inst_pc` is 0x100.
  - `imem_req_addr` = 0x100 one cycle after the redirect.
- Redirect in the same cycle as a pop and a request handshake:
  - The popped instruction is delivered once.
  - The in-flight request is dropped.
  - The first post-redirect instruction has the target PC.
- `imem_req_ready` held low for 5 cycles: `imem_req_addr` stays stable.
- With `FETCH_MISALIGN_TRAP_EN`, redirect to 0x202:
  - `misalign_valid`=1 with addr 0x202; no requests issued.
  - A subsequent redirect to 0x300 resumes fetching at 0x300.
- Without `FETCH_MISALIGN_TRAP_EN`, redirect to 0x202: fetch resumes at 0x200.
